// File: rtl/spi_display_seq_if.sv
// rtl/spi_display_seq_if.sv - source/sink/control bundle between a word source, the sequencer and spi_display
interface spi_display_seq_if;
  logic       tick;
  logic [9:0] in_data;
  logic       in_empty;
  logic       in_get;
  logic       out_dc;
  logic [7:0] out_data;
  logic       out_empty;
  logic       out_get;
  logic       spi_idle;
  logic       lcd_reset;
  logic       backlight;
  logic       busy;

  modport master (
    output tick, in_data, in_empty, out_get, spi_idle,
    input  in_get, out_dc, out_data, out_empty, lcd_reset, backlight, busy
  );

  modport slave (
    input  tick, in_data, in_empty, out_get, spi_idle,
    output in_get, out_dc, out_data, out_empty, lcd_reset, backlight, busy
  );
endinterface

// File: rtl/spi_display_seq.sv
// rtl/spi_display_seq.sv - command sequencer: pass-through, delays, reset pulse, run-length fill, backlight
module spi_display_seq #(
  parameter int GUARD = 4
) (
  input  logic             clock,
  input  logic             reset,
  spi_display_seq_if.slave bus
);

  localparam int GW = $clog2(GUARD + 1);

  localparam logic [1:0] OP_DELAY  = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_REPEAT = 2'b10;
  localparam logic [1:0] OP_SET    = 2'b11;

  typedef enum logic [2:0] {
    PASS, DRAIN, DELAY, RSTPULSE, REP_LO, REP_VAL, REP_EMIT
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    op;
  logic [5:0]    arg;
  logic [13:0]   count;
  logic [GW-1:0] guard;
  logic [8:0]    word;
  logic          lcd_reset_q;
  logic          backlight_q;

  logic head_ctl;
  logic pass_empty;
  logic guard_done;
  logic count_zero;

  // Head word is an in-band command only when the source actually has a word.
  assign head_ctl   = ~bus.in_empty & bus.in_data[9];
  assign pass_empty = bus.in_empty | bus.in_data[9];
  // This cycle is the GUARD-th consecutive idle cycle of the SPI link.
  assign guard_done = bus.spi_idle && (guard == GW'(GUARD - 1));
  assign count_zero = (count == '0);

  assign bus.lcd_reset = lcd_reset_q;
  assign bus.backlight = backlight_q;
  assign bus.busy      = (state != PASS);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= PASS;
    else       state <= state_nx;
  end

  // Next state plus the combinational source/sink handshake.
  always_comb begin
    state_nx      = state;
    bus.in_get    = 1'b0;
    bus.out_empty = 1'b1;
    bus.out_dc    = word[8];
    bus.out_data  = word[7:0];
    case (state)
      PASS: begin
        bus.out_dc    = bus.in_data[8];
        bus.out_data  = bus.in_data[7:0];
        bus.out_empty = pass_empty;
        bus.in_get    = head_ctl | (bus.out_get & ~pass_empty);
        if (head_ctl) begin
          case (bus.in_data[7:6])
            OP_DELAY, OP_RESET: state_nx = DRAIN;
            OP_REPEAT:          state_nx = REP_LO;
            default:            state_nx = PASS;
          endcase
        end
      end
      DRAIN: begin
        if (guard_done) state_nx = (op == OP_RESET) ? RSTPULSE : DELAY;
      end
      DELAY, RSTPULSE: begin
        if (bus.tick && count_zero) state_nx = PASS;
      end
      REP_LO: begin
        bus.in_get = ~bus.in_empty;
        if (!bus.in_empty) state_nx = REP_VAL;
      end
      REP_VAL: begin
        bus.in_get = ~bus.in_empty;
        if (!bus.in_empty) state_nx = REP_EMIT;
      end
      REP_EMIT: begin
        bus.out_empty = 1'b0;
        if (bus.out_get && count_zero) state_nx = PASS;
      end
      default: state_nx = PASS;
    endcase
  end

  // Command latch, guard/timer/fill counters and the registered panel controls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op          <= '0;
      arg         <= '0;
      count       <= '0;
      guard       <= '0;
      word        <= '0;
      lcd_reset_q <= 1'b0;
      backlight_q <= 1'b0;
    end else begin
      case (state)
        PASS: begin
          guard <= '0;
          if (head_ctl) begin
            op  <= bus.in_data[7:6];
            arg <= bus.in_data[5:0];
            if (bus.in_data[7:6] == OP_SET)    backlight_q  <= bus.in_data[0];
            if (bus.in_data[7:6] == OP_REPEAT) count[13:8]  <= bus.in_data[5:0];
          end
        end
        DRAIN: begin
          if (!bus.spi_idle) begin
            guard <= '0;
          end else if (guard_done) begin
            guard <= '0;
            count <= {8'd0, arg};
            if (op == OP_RESET) lcd_reset_q <= 1'b1;
          end else begin
            guard <= guard + 1'b1;
          end
        end
        DELAY, RSTPULSE: begin
          if (bus.tick) begin
            if (count_zero) lcd_reset_q <= 1'b0;
            else            count       <= count - 1'b1;
          end
        end
        REP_LO: begin
          if (!bus.in_empty) count[7:0] <= bus.in_data[7:0];
        end
        REP_VAL: begin
          if (!bus.in_empty) word <= bus.in_data[8:0];
        end
        REP_EMIT: begin
          if (bus.out_get && !count_zero) count <= count - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_display_seq.sv
// tb/tb_spi_display_seq.sv - randomized self-checking bench for spi_display_seq
module tb_spi_display_seq;
  localparam int GUARD = 4;
  localparam int LOGN  = 4096;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  spi_display_seq_if bus();

  spi_display_seq #(.GUARD(GUARD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp;
  int n_bad;

  logic [9:0] src_q[$];
  logic [9:0] model_q[$];
  logic [8:0] sink_q[$];
  logic [8:0] exp_q[$];
  bit         bl_model;

  int cyc;
  int idle_from;
  int tick_per;
  int tick_ph;
  bit stall;

  bit         lg_get [LOGN];
  bit         lg_oe  [LOGN];
  bit         lg_oget[LOGN];
  bit         lg_busy[LOGN];
  bit         lg_lcd [LOGN];
  bit         lg_tick[LOGN];
  logic [9:0] lg_in  [LOGN];
  logic [8:0] lg_out [LOGN];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic bit tick_at(input int i);
    if (tick_per <= 0) return 1'b0;
    return (i % tick_per) == tick_ph;
  endfunction

  task automatic begin_scn();
    src_q.delete();
    model_q.delete();
    sink_q.delete();
    exp_q.delete();
    cyc = 0;
  endtask

  task automatic add(input logic [9:0] w);
    src_q.push_back(w);
    model_q.push_back(w);
  endtask

  // Reference: expand the word list into the words the sink must see and the final backlight.
  task automatic model_stream();
    int         i;
    int         n;
    logic [9:0] x;
    logic [9:0] lo;
    logic [9:0] val;
    i = 0;
    while (i < model_q.size()) begin
      x = model_q[i];
      if (!x[9]) begin
        exp_q.push_back(x[8:0]);
        i++;
      end else if (x[7:6] == 2'b11) begin
        bl_model = x[0];
        i++;
      end else if (x[7:6] == 2'b10) begin
        lo  = model_q[i + 1];
        val = model_q[i + 2];
        n   = int'(x[5:0]) * 256 + int'(lo[7:0]) + 1;
        for (int k = 0; k < n; k++) exp_q.push_back(val[8:0]);
        i += 3;
      end else begin
        i++;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clock);
    bus.in_empty = (src_q.size() == 0);
    bus.in_data  = (src_q.size() != 0) ? src_q[0] : 10'h000;
    bus.out_get  = stall ? ($urandom_range(0, 1) != 0) : 1'b1;
    bus.tick     = tick_at(cyc);
    bus.spi_idle = (cyc >= idle_from);
    #1;
    if (cyc < LOGN) begin
      lg_get[cyc]  = bus.in_get;
      lg_oe[cyc]   = bus.out_empty;
      lg_oget[cyc] = bus.out_get;
      lg_busy[cyc] = bus.busy;
      lg_lcd[cyc]  = bus.lcd_reset;
      lg_tick[cyc] = bus.tick;
      lg_in[cyc]   = bus.in_data;
      lg_out[cyc]  = {bus.out_dc, bus.out_data};
    end
    if (bus.in_get) void'(src_q.pop_front());
    if (bus.out_get && !bus.out_empty) sink_q.push_back({bus.out_dc, bus.out_data});
    cyc++;
  endtask

  task automatic run_drain(input int budget);
    int quiet;
    int n;
    quiet = 0;
    n = 0;
    while (quiet < 3 && n < budget) begin
      cycle();
      n++;
      if (src_q.size() == 0 && !bus.busy) quiet++;
      else                                quiet = 0;
    end
    check_eq("drain_done", quiet, 3);
  endtask

  task automatic check_stream(input string tag);
    int bad;
    bad = 0;
    check_eq({tag, "_len"}, sink_q.size(), exp_q.size());
    for (int i = 0; i < sink_q.size() && i < exp_q.size(); i++)
      if (sink_q[i] !== exp_q[i]) bad++;
    check_eq({tag, "_words"}, bad, 0);
  endtask

  task automatic run_timed(input int op, input int arg, input int idle0, input int per, input int ph);
    int         c0, s, t, nt, offer, first_hi, last_hi, hi_ticks, busy_bad, lcd_cnt;
    logic [9:0] cw;
    begin_scn();
    stall = 1'b0; idle_from = idle0; tick_per = per; tick_ph = ph;
    cw = 10'h200 | 10'(op * 64) | 10'(arg);
    add(10'h02C); add(cw); add(10'h1FF);
    model_stream();
    run_drain(1500);
    c0 = -1;
    for (int i = 0; i < cyc && i < LOGN; i++) if (c0 < 0 && lg_get[i] && lg_in[i][9]) c0 = i;
    check_eq("ctl_consumed_at", c0, 1);
    s  = (c0 + 1 > idle0) ? c0 + 1 : idle0;
    t  = s + GUARD;
    nt = 0;
    while (t < s + GUARD + 1000) begin
      if (tick_at(t)) begin
        nt++;
        if (nt == arg + 1) break;
      end
      t++;
    end
    offer = -1;
    for (int i = c0 + 1; i < cyc && i < LOGN; i++) if (offer < 0 && !lg_oe[i]) offer = i;
    check_eq(op == 1 ? "rst_resume_cycle" : "dly_resume_cycle", offer, t + 1);
    busy_bad = 0;
    for (int i = c0 + 1; i <= t && i < LOGN; i++) if (!lg_busy[i]) busy_bad++;
    check_eq("wait_busy", busy_bad, 0);
    first_hi = -1; last_hi = -1; hi_ticks = 0; lcd_cnt = 0;
    for (int i = 0; i < cyc && i < LOGN; i++) begin
      if (lg_lcd[i]) begin
        if (first_hi < 0) first_hi = i;
        last_hi = i;
        lcd_cnt++;
        if (lg_tick[i]) hi_ticks++;
      end
    end
    if (op == 1) begin
      check_eq("rst_rise_cycle", first_hi, s + GUARD);
      check_eq("rst_fall_cycle", last_hi, t);
      check_eq("rst_pulse_ticks", hi_ticks, arg + 1);
    end else begin
      check_eq("dly_no_lcd_reset", lcd_cnt, 0);
    end
    check_stream("timed");
  endtask

  task automatic run_fill(input logic [9:0] w_hi, input logic [9:0] w_lo, input logic [9:0] w_val,
                          input logic [9:0] w_tail, input string tag);
    int last;
    int nxt;
    begin_scn();
    stall = 1'b1; idle_from = 0; tick_per = 0; tick_ph = 0;
    add(w_hi); add(w_lo); add(w_val); add(w_tail);
    model_stream();
    run_drain(4000);
    check_stream(tag);
    last = -1;
    for (int i = 0; i < cyc && i < LOGN; i++) if (lg_oget[i] && !lg_oe[i] && lg_busy[i]) last = i;
    nxt = -1;
    if (last >= 0 && last + 1 < LOGN && !lg_oe[last + 1]) nxt = int'(lg_out[last + 1]);
    check_eq({tag, "_next_no_gap"}, nxt, int'(w_tail[8:0]));
  endtask

  task automatic run_mixed(input int items);
    int r;
    begin_scn();
    stall = 1'b1; idle_from = 0; tick_per = 3; tick_ph = $urandom_range(0, 2);
    for (int k = 0; k < items; k++) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        add(10'($urandom_range(0, 511)));
      end else if (r == 5) begin
        add(10'h3C0 | 10'($urandom_range(0, 63)));
      end else if (r < 8) begin
        add(10'h280);
        add(10'($urandom_range(0, 20)));
        add(10'($urandom_range(0, 1023)));
      end else begin
        add(10'h200 | 10'($urandom_range(0, 1) * 64) | 10'($urandom_range(0, 3)));
      end
    end
    model_stream();
    run_drain(4000);
    check_stream("mixed");
    check_eq("mixed_backlight", int'(bus.backlight), int'(bl_model));
  endtask

  initial begin
    int bad, busy_seen, n, per;
    logic [13:0] cnt;
    logic        b;
    n_cmp = 0; n_bad = 0; bl_model = 1'b0;
    bus.tick = 1'b0; bus.in_data = '0; bus.in_empty = 1'b1; bus.out_get = 1'b0; bus.spi_idle = 1'b1;
    stall = 1'b0; idle_from = 0; tick_per = 0; tick_ph = 0; cyc = 0;

    repeat (2) @(negedge clock);
    #1;
    check_eq("rst_out_empty", int'(bus.out_empty), 1);
    check_eq("rst_lcd_reset", int'(bus.lcd_reset), 0);
    check_eq("rst_backlight", int'(bus.backlight), 0);
    check_eq("rst_busy", int'(bus.busy), 0);
    check_eq("rst_in_get", int'(bus.in_get), 0);
    @(negedge clock);
    reset = 1'b0;

    // Pass-through with an always-ready sink.
    begin_scn();
    stall = 1'b0; idle_from = 0; tick_per = 0;
    add(10'h036); add(10'h1AA); add(10'h155);
    model_stream();
    run_drain(50);
    check_stream("pass");
    check_eq("pass_first_offer", lg_oe[0] ? -1 : int'(lg_out[0]), 'h036);
    bad = 0; busy_seen = 0;
    for (int i = 0; i < cyc && i < LOGN; i++) begin
      if (lg_get[i] != (lg_oget[i] && !lg_oe[i])) bad++;
      if (lg_busy[i]) busy_seen++;
    end
    check_eq("pass_get_same_cycle", bad, 0);
    check_eq("pass_busy", busy_seen, 0);

    // Random data words against a stalling sink.
    begin_scn();
    stall = 1'b1;
    for (int k = 0; k < 24; k++) add(10'($urandom_range(0, 511)));
    model_stream();
    run_drain(500);
    check_stream("pass_rand");

    // Timed commands: the listed DELAY and RESET cases, then random ones.
    run_timed(0, 3, 10, 8, $urandom_range(0, 7));
    run_timed(1, 1, 0, 8, $urandom_range(0, 7));
    for (int k = 0; k < 6; k++) begin
      per = $urandom_range(2, 8);
      run_timed($urandom_range(0, 1), $urandom_range(0, 6), $urandom_range(0, 12), per, $urandom_range(0, per - 1));
    end

    // Fills: the 300-word case, count 0, and random counts.
    run_fill(10'h281, 10'h02B, 10'h1F8, 10'h0C3, "fill300");
    run_fill(10'h280, 10'h000, 10'h155, 10'h012, "fill_zero");
    for (int k = 0; k < 3; k++) begin
      cnt = 14'($urandom_range(0, 400));
      run_fill(10'h280 | 10'(cnt[13:8]), 10'($urandom_range(0, 3) * 256) | 10'(cnt[7:0]),
               10'($urandom_range(0, 1023)), 10'($urandom_range(0, 511)), "fill_rand");
    end

    // Backlight control.
    begin_scn(); stall = 1'b0;
    add(10'h3C1); model_stream(); run_drain(20);
    check_eq("bl_on", int'(bus.backlight), 1);
    check_eq("bl_on_no_output", sink_q.size(), 0);
    begin_scn();
    add(10'h3C0); model_stream(); run_drain(20);
    check_eq("bl_off", int'(bus.backlight), 0);
    for (int k = 0; k < 4; k++) begin
      begin_scn();
      b = $urandom_range(0, 1) != 0;
      add(10'h3C0 | 10'($urandom_range(0, 31) * 2) | 10'(b));
      model_stream(); run_drain(20);
      check_eq("bl_rand", int'(bus.backlight), int'(bl_model));
    end

    run_mixed(30);
    run_mixed(30);

    // Reset in the middle of a fill.
    begin_scn(); stall = 1'b1; idle_from = 0; tick_per = 0;
    add(10'h3C1); add(10'h281); add(10'h02B); add(10'h1F8);
    n = 0;
    while (sink_q.size() < 100 && n < 2000) begin
      cycle();
      n++;
    end
    check_eq("mid_fill_reached", sink_q.size(), 100);
    check_eq("mid_busy_before", int'(bus.busy), 1);
    check_eq("mid_bl_before", int'(bus.backlight), 1);
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check_eq("mid_rst_out_empty", int'(bus.out_empty), 1);
    check_eq("mid_rst_lcd_reset", int'(bus.lcd_reset), 0);
    check_eq("mid_rst_backlight", int'(bus.backlight), 0);
    check_eq("mid_rst_busy", int'(bus.busy), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    bl_model = 1'b0;
    begin_scn(); stall = 1'b0;
    add(10'h0AB);
    model_stream();
    run_drain(50);
    check_stream("after_rst");
    check_eq("after_rst_offer", lg_oe[0] ? -1 : int'(lg_out[0]), 'h0AB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not reach its summary in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_display_seq.md
Name: spi_display_seq

Overview:
- Command sequencer between a word source (command ROM or FIFO) and spi_display.
- Passes ordinary {dc, data} words straight through.
- Interprets in-band control words:
  - timed delays measured after the SPI link has drained,
  - display hardware-reset pulse,
  - run-length fill (repeat one word up to 16384 times),
  - backlight control.
- Lets one ROM image carry a panel's complete power-up and clear-screen sequence.

Parameters:
- GUARD, 4: consecutive cycles spi_idle must be 1 before a DELAY or RESET timer starts (covers the get-to-cs_n latency of spi_display).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick  in  1  single-cycle timebase strobe (from strobe timer); the unit for DELAY and RESET
- in_data  in  10  head word of the source, show-ahead: {ctl, dc, data[7:0]}
- in_empty  in  1  source has no word
- in_get  out  1  pop the head word (combinational)
- out_dc  out  1  dc to spi_display
- out_data  out  8  data byte to spi_display
- out_empty  out  1  no word offered to spi_display
- out_get  in  1  spi_display pops the offered word; ignored while out_empty=1
- spi_idle  in  1  spi_display idle (cs_n high)
- lcd_reset  out  1  display hardware reset, active-high (registered)
- backlight  out  1  backlight enable (registered)
- busy  out  1  state != PASS

Behaviour:
- Reset (async): state=PASS, lcd_reset=0, backlight=0, count=0, guard=0, latched word=0.
- Control word: ctl=1. op=data[7:6], arg=data[5:0].
  - op 00 DELAY: wait arg+1 ticks.
  - op 01 RESET: lcd_reset=1 for arg+1 ticks.
  - op 10 REPEAT: arg is count[13:8].
  - op 11 SET: backlight<=data[0]; all other bits ignored.
- PASS state, head is a data word (ctl=0):
  - out_empty = in_empty | in_data[9]; out_{dc,data} = in_data[8:0].
  - in_get = out_get & ~out_empty. Zero added latency, fully combinational.
- PASS state, head is a control word:
  - out_empty=1; in_get=1 that cycle; opcode and arg are latched.
  - SET: backlight updates next cycle; state stays PASS.
  - DELAY/RESET: go to DRAIN.
  - REPEAT: count[13:8]<=arg; go to REP_LO.
- DRAIN:
  - guard counts consecutive cycles with spi_idle=1; spi_idle=0 clears guard.
  - When guard reaches GUARD, load count<=arg and go to DELAY or RSTPULSE.
  - For RESET, lcd_reset rises on that same transition edge.
- DELAY / RSTPULSE:
  - count decrements on each tick.
  - A tick on the tick where count==0 returns to PASS; RSTPULSE also drops lcd_reset on that edge.
  - A tick in the load cycle is not counted.
  - Pulse/delay length is exactly arg+1 ticks.
- REP_LO: wait for !in_empty, pop one word, count[7:0]<=in_data[7:0] (ctl and dc bits ignored), go to REP_VAL.
- REP_VAL: wait for !in_empty, pop one word, latch in_data[8:0] (ctl ignored), go to REP_EMIT.
- REP_EMIT:
  - out_empty=0, outputs show the latched word, in_get=0.
  - Each out_get decrements count; out_get with count==0 returns to PASS.
  - Emits count+1 words (1..16384).
- Outside PASS, REP_LO and REP_VAL, in_get=0. out_empty=1 everywhere except PASS data words and REP_EMIT.
- Empty source in PASS: idle, busy=0.
- Reset mid-operation: immediate return to reset state; lcd_reset and backlight drop asynchronously.

Test Plan:
1. Pass-through: source holds 0x036,0x1AA,0x155 with an always-ready sink.
   - Sink receives {dc,data} = 0,36 / 1,AA / 1,55 in order.
   - in_get asserts in the same cycle as each out_get; busy stays 0.
2. DELAY: words 0x02C, 0x203 (DELAY arg=3), 0x1FF; hold spi_idle=0 for 10 cycles after the first word, then 1; tick every 8 cycles.
   - Timer starts only after GUARD=4 idle cycles.
   - 0x1FF is offered exactly 4 ticks after the timer starts.
   - busy=1 throughout the wait.
3. RESET: word 0x241 (RESET arg=1) with spi_idle=1.
   - lcd_reset high for exactly 2 ticks, starting GUARD cycles after the word is consumed.
   - Output then returns to 0 and PASS resumes.
4. REPEAT fill: words 0x281, 0x02B (count=0x12B=299), 0x1F8.
   - Sink sees exactly 300 words {1,F8}.
   - Sink stalls (out_get=0 on random cycles) do not change the count.
   - The next source word follows without a gap.
5. SET and boundary: 0x3C1 then 0x3C0 gives backlight 1 then 0.
   - REPEAT with count 0 (words 0x280, 0x000, 0x155) emits exactly one word {1,55}.
6. Reset mid-fill: assert reset after 100 of 300 fill words.
   - out_empty=1, lcd_reset=0, backlight=0, busy=0 immediately.
   - After release, the next source word passes through normally.
